// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/response bundle between fetch_sequencer (master) and imem (slave).
// Handshake: a request transfers on a rising edge where req & gnt; addr is held while req & !gnt;
// exactly one rvalid pulse (with rdata) follows each transfer, at least one cycle later.
interface fetch_sequencer_if #(
   parameter int ADDR_W = 32
);
   logic              req;
   logic [ADDR_W-1:0] addr;
   logic              gnt;
   logic              rvalid;
   logic [31:0]       rdata;

   modport master (output req, output addr, input gnt, input rvalid, input rdata);
   modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, issues one imem request at a time, registers words for decode.
// Optional macro FETCH_MISALIGN_CHK_EN: misaligned redirect raises sticky misalign and halts fetch.
module fetch_sequencer #(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   fetch_sequencer_if.master imem,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              stall,
   output logic              if_valid,
   output logic [ADDR_W-1:0] if_pc,
   output logic [ADDR_W-1:0] if_npc,
   output logic [31:0]       if_instr,
`ifdef FETCH_MISALIGN_CHK_EN
   output logic              misalign,
`endif
   output logic [2:0]        dbg_state_o
);
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_WAIT  = 3'd2,
      S_HOLD  = 3'd3,
      S_DRAIN = 3'd4
`ifdef FETCH_MISALIGN_CHK_EN
      , S_HALT = 3'd5
`endif
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              if_valid_q, if_valid_d;
   logic [ADDR_W-1:0] if_pc_q, if_pc_d;
   logic [ADDR_W-1:0] if_npc_q, if_npc_d;
   logic [31:0]       if_instr_q, if_instr_d;
   logic              redirect_ok;
   logic [ADDR_W-1:0] redirect_tgt;
`ifdef FETCH_MISALIGN_CHK_EN
   logic              misalign_q, misalign_d;
   logic              redirect_bad;
`endif

   // Reset is active-high even though the port is called rst_n.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_PC;
         if_valid_q <= 1'b0;
         if_pc_q    <= '0;
         if_npc_q   <= '0;
         if_instr_q <= '0;
`ifdef FETCH_MISALIGN_CHK_EN
         misalign_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         if_valid_q <= if_valid_d;
         if_pc_q    <= if_pc_d;
         if_npc_q   <= if_npc_d;
         if_instr_q <= if_instr_d;
`ifdef FETCH_MISALIGN_CHK_EN
         misalign_q <= misalign_d;
`endif
      end
   end

   assign redirect_tgt = redirect_pc & ~ADDR_W'(3);

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      if_valid_d  = if_valid_q;
      if_pc_d     = if_pc_q;
      if_npc_d    = if_npc_q;
      if_instr_d  = if_instr_q;
`ifdef FETCH_MISALIGN_CHK_EN
      misalign_d   = misalign_q;
      redirect_ok  = redirect && (state_q != S_HALT) && (redirect_pc[1:0] == 2'b00);
      redirect_bad = redirect && (state_q != S_HALT) && (redirect_pc[1:0] != 2'b00);
`else
      redirect_ok  = redirect;
`endif

      if (if_valid_q && !stall) if_valid_d = 1'b0;

      case (state_q)
         S_IDLE:  state_d = S_REQ;
         S_REQ:   if (imem.gnt) state_d = S_WAIT;
         S_WAIT: begin
            if (imem.rvalid) begin
               if_pc_d    = pc_q;
               if_npc_d   = pc_q + ADDR_W'(4);
               if_instr_d = imem.rdata;
               if_valid_d = 1'b1;
               pc_d       = pc_q + ADDR_W'(4);
               state_d    = (!if_valid_q || !stall) ? S_REQ : S_HOLD;
            end
         end
         S_HOLD:  if (!stall) state_d = S_REQ;
         S_DRAIN: if (imem.rvalid) state_d = S_REQ;
`ifdef FETCH_MISALIGN_CHK_EN
         S_HALT:  if_valid_d = 1'b0;
`endif
         default: state_d = S_IDLE;
      endcase

      // Redirect overrides everything above, including a word landing this same edge.
      if (redirect_ok) begin
         pc_d       = redirect_tgt;
         if_valid_d = 1'b0;
         if_pc_d    = if_pc_q;
         if_npc_d   = if_npc_q;
         if_instr_d = if_instr_q;
         if (state_q == S_WAIT || state_q == S_DRAIN)
            state_d = imem.rvalid ? S_REQ : S_DRAIN;
         else if (state_q == S_REQ && imem.gnt)
            state_d = S_DRAIN;
         else
            state_d = S_REQ;
      end
`ifdef FETCH_MISALIGN_CHK_EN
      if (redirect_bad) begin
         misalign_d = 1'b1;
         if_valid_d = 1'b0;
         if_pc_d    = if_pc_q;
         if_npc_d   = if_npc_q;
         if_instr_d = if_instr_q;
         pc_d       = pc_q;
         state_d    = S_HALT;
      end
`endif
   end

   assign imem.req    = (state_q == S_REQ);
   assign imem.addr   = pc_q;
   assign if_valid    = if_valid_q;
   assign if_pc       = if_pc_q;
   assign if_npc      = if_npc_q;
   assign if_instr    = if_instr_q;
   assign dbg_state_o = state_q;
`ifdef FETCH_MISALIGN_CHK_EN
   assign misalign    = misalign_q;
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: inputs driven and outputs checked on the falling edge.
module tb_fetch_sequencer;
   localparam int ADDR_W = 32;
   localparam logic [63:0] ST_IDLE = 64'd0, ST_REQ = 64'd1, ST_WAIT = 64'd2, ST_HOLD = 64'd3,
                           ST_DRAIN = 64'd4, ST_HALT = 64'd5;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_pc;
   logic              stall;
   logic              if_valid;
   logic [ADDR_W-1:0] if_pc, if_npc;
   logic [31:0]       if_instr;
   logic [2:0]        dbg_state;
`ifdef FETCH_MISALIGN_CHK_EN
   logic              misalign;
`endif

   int n_cmp = 0;
   int n_err = 0;

   fetch_sequencer_if #(.ADDR_W(ADDR_W)) imem ();

   fetch_sequencer #(.ADDR_W(ADDR_W), .RESET_PC('0)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem        (imem),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .stall       (stall),
      .if_valid    (if_valid),
      .if_pc       (if_pc),
      .if_npc      (if_npc),
      .if_instr    (if_instr),
`ifdef FETCH_MISALIGN_CHK_EN
      .misalign    (misalign),
`endif
      .dbg_state_o (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // One memory transaction starting in REQ: optional gnt delay (with stray rvalids), gnt, rvalid.
   task automatic xact(input logic [31:0] a, input logic [31:0] d, input int gnt_wait, input bit stray);
      check("xact_req", imem.req, 1);
      check("xact_addr", imem.addr, a);
      for (int i = 0; i < gnt_wait; i++) begin
         imem.gnt    = 1'b0;
         imem.rvalid = stray;
         imem.rdata  = 32'hBAD0_0000 | i;
         tick();
         check("wait_req", imem.req, 1);
         check("wait_addr", imem.addr, a);
         check("wait_state", dbg_state, ST_REQ);
         if (stray) check("stray_ignored", if_valid, 0);
      end
      imem.rvalid = 1'b0;
      imem.gnt    = 1'b1;
      tick();
      imem.gnt = 1'b0;
      check("gnt_state", dbg_state, ST_WAIT);
      check("gnt_req_low", imem.req, 0);
      imem.rvalid = 1'b1;
      imem.rdata  = d;
      tick();
      imem.rvalid = 1'b0;
   endtask

   initial begin
      imem.gnt = 1'b0; imem.rvalid = 1'b0; imem.rdata = '0;
      redirect = 1'b0; redirect_pc = '0; stall = 1'b0;

      // reset values
      repeat (3) tick();
      check("rst_state", dbg_state, ST_IDLE);
      check("rst_req", imem.req, 0);
      check("rst_addr", imem.addr, 0);
      check("rst_valid", if_valid, 0);
      check("rst_pc", if_pc, 0);
      check("rst_npc", if_npc, 0);
      check("rst_instr", if_instr, 0);
      rst_n = 1'b0;
      tick();
      check("idle_to_req", dbg_state, ST_REQ);

      // back-to-back fetches 0,4,8
      xact(32'h0, 32'hA000_0000, 0, 1'b0);
      check("w0_valid", if_valid, 1);
      check("w0_pc", if_pc, 32'h0);
      check("w0_npc", if_npc, 32'h4);
      check("w0_instr", if_instr, 32'hA000_0000);
      xact(32'h4, 32'hA000_0001, 0, 1'b0);
      check("w1_pc", if_pc, 32'h4);
      check("w1_npc", if_npc, 32'h8);
      check("w1_instr", if_instr, 32'hA000_0001);
      xact(32'h8, 32'hA000_0002, 0, 1'b0);
      check("w2_pc", if_pc, 32'h8);
      check("w2_npc", if_npc, 32'hC);
      check("w2_next_addr", imem.addr, 32'hC);

      // stall: word at 0xC lands while decode is busy -> HOLD, outputs frozen
      stall = 1'b1;
      xact(32'hC, 32'hA000_0003, 0, 1'b0);
      check("hold_state", dbg_state, ST_HOLD);
      check("hold_pc", if_pc, 32'hC);
      check("hold_instr", if_instr, 32'hA000_0003);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_req", imem.req, 0);
         check("stall_valid", if_valid, 1);
         check("stall_pc", if_pc, 32'hC);
         check("stall_npc", if_npc, 32'h10);
         check("stall_instr", if_instr, 32'hA000_0003);
      end
      stall = 1'b0;
      tick();
      check("release_valid", if_valid, 0);
      check("release_req", imem.req, 1);
      check("release_addr", imem.addr, 32'h10);

      // redirect while waiting: stale response dropped
      imem.gnt = 1'b1;
      tick();
      imem.gnt = 1'b0;
      redirect = 1'b1; redirect_pc = 32'h100;
      tick();
      redirect = 1'b0;
      check("drain_state", dbg_state, ST_DRAIN);
      check("drain_req", imem.req, 0);
      check("drain_valid", if_valid, 0);
      imem.rvalid = 1'b1; imem.rdata = 32'hDEAD_DEAD;
      tick();
      imem.rvalid = 1'b0;
      check("stale_valid", if_valid, 0);
      check("stale_pc", if_pc, 32'hC);
      check("redir_addr", imem.addr, 32'h100);
      check("redir_req", imem.req, 1);

      // redirect to top of address space: pc+4 wraps
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect = 1'b0;
      check("top_state", dbg_state, ST_REQ);
      xact(32'hFFFF_FFFC, 32'hA000_0004, 0, 1'b0);
      check("wrap_pc", if_pc, 32'hFFFF_FFFC);
      check("wrap_npc", if_npc, 32'h0);
      check("wrap_instr", if_instr, 32'hA000_0004);
      check("wrap_addr", imem.addr, 32'h0);

      // gnt withheld 10 cycles with stray rvalids
      xact(32'h0, 32'hA000_0005, 10, 1'b1);
      check("slow_valid", if_valid, 1);
      check("slow_pc", if_pc, 32'h0);
      check("slow_npc", if_npc, 32'h4);
      check("slow_instr", if_instr, 32'hA000_0005);

      // redirect coinciding with rvalid in WAIT: data discarded, straight to REQ
      imem.gnt = 1'b1;
      tick();
      imem.gnt = 1'b0;
      redirect = 1'b1; redirect_pc = 32'h200;
      imem.rvalid = 1'b1; imem.rdata = 32'hBEEF_BEEF;
      tick();
      redirect = 1'b0; imem.rvalid = 1'b0;
      check("coinc_state", dbg_state, ST_REQ);
      check("coinc_valid", if_valid, 0);
      check("coinc_instr", if_instr, 32'hA000_0005);
      check("coinc_addr", imem.addr, 32'h200);

      // redirect coinciding with gnt in REQ: response must be drained
      imem.gnt = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
      tick();
      imem.gnt = 1'b0; redirect = 1'b0;
      check("gntredir_state", dbg_state, ST_DRAIN);
      check("gntredir_req", imem.req, 0);
      imem.rvalid = 1'b1; imem.rdata = 32'h1234_5678;
      tick();
      imem.rvalid = 1'b0;
      check("gntredir_addr", imem.addr, 32'h40);
      check("gntredir_valid", if_valid, 0);

`ifdef FETCH_MISALIGN_CHK_EN
      redirect = 1'b1; redirect_pc = 32'h102;
      tick();
      check("mis_flag", misalign, 1);
      check("mis_state", dbg_state, ST_HALT);
      check("mis_req", imem.req, 0);
      redirect_pc = 32'h500; imem.rvalid = 1'b1;
      repeat (3) tick();
      redirect = 1'b0; imem.rvalid = 1'b0;
      check("halt_sticky", misalign, 1);
      check("halt_req", imem.req, 0);
      check("halt_valid", if_valid, 0);
      rst_n = 1'b1;
      tick();
      check("halt_rst_flag", misalign, 0);
      check("halt_rst_state", dbg_state, ST_IDLE);
      rst_n = 1'b0;
      tick();
      check("halt_restart_addr", imem.addr, 32'h0);
`else
      redirect = 1'b1; redirect_pc = 32'h303;
      tick();
      redirect = 1'b0;
      check("lowbits_state", dbg_state, ST_REQ);
      check("lowbits_addr", imem.addr, 32'h300);
`endif

      // reset mid-transaction: in-flight response ignored afterwards
      imem.gnt = 1'b1;
      tick();
      imem.gnt = 1'b0;
      check("mid_wait", dbg_state, ST_WAIT);
      rst_n = 1'b1;
      #1;
      check("mid_rst_state", dbg_state, ST_IDLE);
      check("mid_rst_addr", imem.addr, 32'h0);
      check("mid_rst_instr", if_instr, 0);
      tick();
      rst_n = 1'b0;
      imem.rvalid = 1'b1; imem.rdata = 32'hCAFE_CAFE;
      tick();
      imem.rvalid = 1'b0;
      check("post_rst_state", dbg_state, ST_REQ);
      check("post_rst_valid", if_valid, 0);
      check("post_rst_instr", if_instr, 0);
      check("post_rst_addr", imem.addr, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
